// File: rtl/hack_loader_pkg.sv
// hack_loader_pkg: shared loader state encoding, frame byte placement and word width
package hack_loader_pkg;
  localparam int LOADER_WORD_W = 16;
  localparam int HI_LSB = 8;
  localparam int LO_LSB = 0;
  typedef enum logic [3:0] {
    IDLE, RST, CNT_H, CNT_L, W_H, W_L, LOAD, WAIT_ACK, S_H, S_L, DONE, ERROR
  } state_t;
endpackage

// File: rtl/stream_to_rom_loader_if.sv
// stream_to_rom_loader_if: host byte stream, SoC ROM loader handshake and session status
interface stream_to_rom_loader_if;
  import hack_loader_pkg::*;
  logic run;
  logic byte_valid;
  logic byte_ready;
  logic [7:0] byte_data;
  logic rom_loader_reset;
  logic rom_loader_load;
  logic [LOADER_WORD_W-1:0] rom_loader_data;
  logic rom_loader_load_received;
  logic rom_loader_ack;
  logic busy;
  logic done;
  logic error;
  logic [15:0] words_loaded;
  modport master (
    input run, byte_valid, byte_data, rom_loader_load_received, rom_loader_ack,
    output byte_ready, rom_loader_reset, rom_loader_load, rom_loader_data,
    busy, done, error, words_loaded
  );
  modport slave (
    output run, byte_valid, byte_data, rom_loader_load_received, rom_loader_ack,
    input byte_ready, rom_loader_reset, rom_loader_load, rom_loader_data,
    busy, done, error, words_loaded
  );
endinterface

// File: rtl/loader_word_assembler.sv
// loader_word_assembler: pairs HI/LO bytes into a word; word is valid while the LO byte is presented
module loader_word_assembler
  import hack_loader_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     take,
  input  logic [7:0]               byte_data,
  output logic [LOADER_WORD_W-1:0] word,
  output logic                     phase
);
  logic [7:0] hi;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      phase <= 1'b0;
    end else if (clr) begin
      phase <= 1'b0;
    end else if (take) begin
      if (!phase) hi <= byte_data;
      phase <= !phase;
    end
  end
  assign word = (LOADER_WORD_W'(hi) << HI_LSB) | (LOADER_WORD_W'(byte_data) << LO_LSB);
endmodule

// File: rtl/stream_to_rom_loader.sv
// stream_to_rom_loader: parses a framed byte stream and programs the SoC ROM through its loader handshake
module stream_to_rom_loader
  import hack_loader_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int RESET_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic                   clk,
  input logic                   reset,
  stream_to_rom_loader_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, state_n;
  logic [TW-1:0] timer;
  logic [7:0] rst_cnt;
  logic [15:0] count;
  logic [DATA_WIDTH-1:0] sum;
  logic [LOADER_WORD_W-1:0] word;
  logic phase, take, lo_take, idle_st;
  assign take = bus.byte_valid && bus.byte_ready;
  assign lo_take = take && phase;
  assign idle_st = state inside {IDLE, RST, DONE, ERROR};
  loader_word_assembler u_asm (
    .clk(clk), .reset(reset), .clr(idle_st), .take(take),
    .byte_data(bus.byte_data), .word(word), .phase(phase)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (bus.run) state_n = RST;
      RST:      if (rst_cnt == 8'(RESET_CYCLES - 1)) state_n = CNT_H;
      CNT_H:    if (take) state_n = CNT_L;
      CNT_L:    if (lo_take) state_n = word == 16'd0 ? S_H : W_H;
      W_H:      if (take) state_n = W_L;
      W_L:      if (lo_take) state_n = LOAD;
      LOAD:     if (bus.rom_loader_load_received) state_n = WAIT_ACK;
      WAIT_ACK: if (bus.rom_loader_ack) state_n = bus.words_loaded + 16'd1 == count ? S_H : W_H;
      S_H:      if (take) state_n = S_L;
      S_L:      if (lo_take) state_n = word == sum ? DONE : ERROR;
      DONE, ERROR: if (!bus.run) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    if (!idle_st && state_n == state && !take && timer == TW'(TIMEOUT_CYCLES - 1)) state_n = ERROR;
    // a dropped run overrides everything, including a timeout on the same edge
    if (!idle_st && !bus.run) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      rst_cnt <= '0;
      count <= '0;
      sum <= '0;
      bus.byte_ready <= 1'b0;
      bus.rom_loader_reset <= 1'b0;
      bus.rom_loader_load <= 1'b0;
      bus.rom_loader_data <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.error <= 1'b0;
      bus.words_loaded <= '0;
    end else begin
      state <= state_n;
      timer <= (idle_st || take || state_n != state) ? '0 : timer + TW'(1);
      rst_cnt <= state == RST ? rst_cnt + 8'd1 : 8'd0;
      if (state == IDLE && state_n == RST) begin
        bus.words_loaded <= '0;
        sum <= '0;
      end
      if (state == CNT_L && lo_take) count <= word;
      if (state == W_L && lo_take) bus.rom_loader_data <= word;
      if (state == WAIT_ACK && state_n inside {W_H, S_H}) begin
        bus.words_loaded <= bus.words_loaded + 16'd1;
        sum <= sum + bus.rom_loader_data;
      end
      bus.byte_ready <= state_n inside {CNT_H, CNT_L, W_H, W_L, S_H, S_L};
      bus.rom_loader_reset <= state_n == RST;
      bus.rom_loader_load <= state_n == LOAD;
      bus.busy <= !(state_n inside {IDLE, DONE, ERROR});
      bus.done <= state_n == DONE;
      bus.error <= state_n == ERROR;
    end
  end
endmodule

// File: tb/tb_stream_to_rom_loader.sv
// tb_stream_to_rom_loader: directed and randomized frames against a word-list reference model and SoC responder
module tb_stream_to_rom_loader;
  import hack_loader_pkg::*;
  localparam int RC = 4;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  stream_to_rom_loader_if ifc ();
  stream_to_rom_loader #(.DATA_WIDTH(16), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .bus(ifc)
  );
  int n = 0;
  int bad = 0;
  logic [15:0] wq[$];
  logic [15:0] seen[$];
  logic [15:0] q0[$];
  bit soc_en = 1'b1;
  bit ack_en = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_sum();
    logic [15:0] s;
    s = '0;
    foreach (wq[i]) s = s + wq[i];
    return s;
  endfunction

  // SoC side: latch one cycle after load appears, ack three cycles after
  initial begin
    ifc.rom_loader_load_received = 1'b0;
    ifc.rom_loader_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (soc_en && ifc.rom_loader_load) begin
        seen.push_back(ifc.rom_loader_data);
        @(negedge clk);
        ifc.rom_loader_load_received = 1'b1;
        @(negedge clk);
        ifc.rom_loader_load_received = 1'b0;
        @(negedge clk);
        if (ack_en) begin
          ifc.rom_loader_ack = 1'b1;
          @(negedge clk);
          ifc.rom_loader_ack = 1'b0;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int unsigned gmax);
    int t;
    repeat ($urandom_range(0, gmax)) @(negedge clk);
    ifc.byte_valid = 1'b1;
    ifc.byte_data = b;
    t = 0;
    while (!ifc.byte_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("byte_accept", 32'(t < 100), 32'd1);
    @(negedge clk);
    ifc.byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] s, input int unsigned gmax);
    logic [15:0] c;
    c = 16'(wq.size());
    send_byte(c[15:8], gmax);
    send_byte(c[7:0], gmax);
    foreach (wq[i]) begin
      send_byte(wq[i][15:8], gmax);
      send_byte(wq[i][7:0], gmax);
    end
    send_byte(s[15:8], gmax);
    send_byte(s[7:0], gmax);
  endtask

  task automatic do_frame(input logic [15:0] s, input int unsigned gmax, input string tag);
    int t;
    bit good;
    good = s == model_sum();
    seen.delete();
    ifc.run = 1'b1;
    send_frame(s, gmax);
    t = 0;
    while (!(ifc.done || ifc.error) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_end_wait"}, 32'(t < 100), 32'd1);
    chk({tag, "_done"}, 32'(ifc.done), 32'(good));
    chk({tag, "_error"}, 32'(ifc.error), 32'(!good));
    chk({tag, "_busy"}, 32'(ifc.busy), 32'd0);
    chk({tag, "_words"}, 32'(ifc.words_loaded), 32'(wq.size()));
    chk({tag, "_nloads"}, 32'(seen.size()), 32'(wq.size()));
    foreach (wq[i]) chk({tag, "_data"}, 32'(seen.size() > i ? seen[i] : 16'hxxxx), 32'(wq[i]));
  endtask

  task automatic stop_run(input string tag);
    ifc.run = 1'b0;
    @(negedge clk);
    chk({tag, "_off_busy"}, 32'(ifc.busy), 32'd0);
    chk({tag, "_off_done"}, 32'(ifc.done), 32'd0);
    chk({tag, "_off_error"}, 32'(ifc.error), 32'd0);
    chk({tag, "_off_ready"}, 32'(ifc.byte_ready), 32'd0);
  endtask

  task automatic rand_words(input int unsigned lo, input int unsigned hi);
    wq.delete();
    repeat ($urandom_range(lo, hi)) wq.push_back(16'($urandom));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int t;
    ifc.run = 1'b0;
    ifc.byte_valid = 1'b0;
    ifc.byte_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_done", 32'(ifc.done), 32'd0);
    chk("rst_error", 32'(ifc.error), 32'd0);
    chk("rst_ready", 32'(ifc.byte_ready), 32'd0);
    chk("rst_lreset", 32'(ifc.rom_loader_reset), 32'd0);
    chk("rst_load", 32'(ifc.rom_loader_load), 32'd0);
    chk("rst_data", 32'(ifc.rom_loader_data), 32'd0);
    chk("rst_words", 32'(ifc.words_loaded), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    wq = '{16'h1234, 16'hABCD};
    do_frame(model_sum(), 0, "basic");
    stop_run("basic");
    do_frame(16'h0000, 0, "badsum");
    stop_run("badsum");
    wq.delete();
    seen.delete();
    ifc.run = 1'b1;
    r = 0;
    repeat (12) begin
      @(negedge clk);
      r += int'(ifc.rom_loader_reset);
    end
    chk("zero_lreset_cycles", 32'(r), 32'(RC));
    do_frame(model_sum(), 0, "zero");
    stop_run("zero");
    ifc.run = 1'b1;
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    repeat (TO - 1) @(negedge clk);
    chk("timeout_early", 32'(ifc.error), 32'd0);
    @(negedge clk);
    chk("timeout_error", 32'(ifc.error), 32'd1);
    chk("timeout_busy", 32'(ifc.busy), 32'd0);
    stop_run("timeout");
    ack_en = 1'b0;
    rand_words(2, 2);
    seen.delete();
    ifc.run = 1'b1;
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(wq[0][15:8], 0);
    send_byte(wq[0][7:0], 0);
    t = 0;
    while (!(seen.size() == 1 && ifc.busy && !ifc.rom_loader_load) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("abort_reach_wait_ack", 32'(t < 50), 32'd1);
    ifc.run = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(ifc.busy), 32'd0);
    chk("abort_load", 32'(ifc.rom_loader_load), 32'd0);
    chk("abort_words", 32'(ifc.words_loaded), 32'd0);
    chk("abort_data0", 32'(seen.size() > 0 ? seen[0] : 16'hxxxx), 32'(wq[0]));
    ack_en = 1'b1;
    repeat (6) @(negedge clk);
    rand_words(3, 3);
    do_frame(model_sum(), 2, "rerun");
    stop_run("rerun");
    soc_en = 1'b0;
    rand_words(1, 1);
    ifc.run = 1'b1;
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(wq[0][15:8], 0);
    send_byte(wq[0][7:0], 0);
    chk("areset_in_load", 32'(ifc.rom_loader_load), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("areset_load", 32'(ifc.rom_loader_load), 32'd0);
    chk("areset_busy", 32'(ifc.busy), 32'd0);
    chk("areset_lreset", 32'(ifc.rom_loader_reset), 32'd0);
    chk("areset_data", 32'(ifc.rom_loader_data), 32'd0);
    ifc.run = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    soc_en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      rand_words(1, 5);
      do_frame(model_sum(), 0, "rand_nogap");
      q0 = seen;
      stop_run("rand_nogap");
      do_frame(k[0] ? model_sum() + 16'd1 : model_sum(), 5, "rand_gap");
      chk("gap_vs_nogap_len", 32'(seen.size()), 32'(q0.size()));
      foreach (q0[i]) chk("gap_vs_nogap_data", 32'(seen.size() > i ? seen[i] : 16'hxxxx), 32'(q0[i]));
      stop_run("rand_gap");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n, bad);
    $finish;
  end
endmodule
